// File: rtl/result_bus_arbiter_pkg.sv
// Shared types and constants for the result/writeback bus arbiter.
// Optional build switch: RESULT_ARB_PERF_CNT_EN (adds perf counter outputs to the top).
package result_bus_arbiter_pkg;

  localparam int RBA_RS_ID_WIDTH = 5;
  localparam int RBA_NUM_UNITS   = 8;
  localparam int RBA_DATA_WIDTH  = 32;

  // Execution-unit positions on the request arrays.
  localparam int UNIT_ADD_SUB = 0;
  localparam int UNIT_MUL     = 1;
  localparam int UNIT_DIV     = 2;
  localparam int UNIT_LOG     = 3;
  localparam int UNIT_ROT     = 4;
  localparam int UNIT_CMP     = 5;
  localparam int UNIT_SYS     = 6;
  localparam int UNIT_TRAP    = 7;

  // One result as it travels on the bus (default widths).
  typedef struct packed {
    logic [RBA_RS_ID_WIDTH-1:0] id;
    logic [RBA_DATA_WIDTH-1:0]  result;
    logic [3:0]                 cr;   // LT, GT, EQ, SO
    logic [2:0]                 xer;  // SO, OV, CA
  } result_bus_t;

  // Round-robin successor of a unit index.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/result_bus_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or after
// ptr_i (wrapping), returning a one-hot grant and its index. Kept generic so
// the load/store port sharing logic can reuse it.
module rr_arbiter #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  input  logic             enable_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  localparam logic [IDX_W:0] N_W = (IDX_W+1)'(N);

  logic [IDX_W:0] cand;

  // Walk ptr, ptr+1, ... wrapping; first requester wins.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    cand    = '0;
    for (int off = 0; off < N; off++) begin
      cand = {1'b0, ptr_i} + (IDX_W+1)'(off);
      if (cand >= N_W) cand = cand - N_W;
      if (enable_i && !any_o && req_i[cand[IDX_W-1:0]]) begin
        any_o                        = 1'b1;
        idx_o                        = cand[IDX_W-1:0];
        grant_o[cand[IDX_W-1:0]]     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/result_bus_arbiter.sv
// Result/writeback bus arbiter: round-robin grant among the execution units,
// one result per cycle into a registered valid/ready output stage.
// Optional build switch: RESULT_ARB_PERF_CNT_EN adds perf_grants/perf_conflicts.
//
// Handshake rules: a unit transfer happens when req_valid[i] & req_ready[i] in
// the same cycle; units must hold req_valid and payload stable until then.
// The bus transfer happens when out_valid & out_ready; while out_valid is high
// and out_ready low, out_* stay stable and no unit is granted.
module result_bus_arbiter
  import result_bus_arbiter_pkg::*;
#(
  parameter int RS_ID_WIDTH = RBA_RS_ID_WIDTH,
  parameter int NUM_UNITS   = RBA_NUM_UNITS,
  parameter int DATA_WIDTH  = RBA_DATA_WIDTH,
  parameter int SRC_W       = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_UNITS-1:0]             req_valid,
  output logic [NUM_UNITS-1:0]             req_ready,
  input  logic [NUM_UNITS*RS_ID_WIDTH-1:0] req_id,
  input  logic [NUM_UNITS*DATA_WIDTH-1:0]  req_result,
  input  logic [NUM_UNITS*4-1:0]           req_cr,
  input  logic [NUM_UNITS*3-1:0]           req_xer,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [RS_ID_WIDTH-1:0]           out_id,
  output logic [DATA_WIDTH-1:0]            out_result,
  output logic [3:0]                       out_cr,
  output logic [2:0]                       out_xer,
  output logic [SRC_W-1:0]                 out_src
`ifdef RESULT_ARB_PERF_CNT_EN
  ,
  output logic [31:0]                      perf_grants,
  output logic [31:0]                      perf_conflicts
`endif
);

  typedef struct packed {
    logic [RS_ID_WIDTH-1:0] id;
    logic [DATA_WIDTH-1:0]  result;
    logic [3:0]             cr;
    logic [2:0]             xer;
  } bus_t;

  localparam logic [SRC_W-1:0] LAST_UNIT = SRC_W'(NUM_UNITS - 1);

  logic [SRC_W-1:0] ptr_q, ptr_d;
  logic             out_valid_q, out_valid_d;
  bus_t             out_q, out_d;
  logic [SRC_W-1:0] out_src_q, out_src_d;

  logic             load;
  logic [SRC_W-1:0] gnt_idx;
  logic             gnt_any;
  bus_t             sel;

  // Output stage can take a new result when empty or being drained; reset blocks grants.
  assign load = (~out_valid_q | out_ready) & ~rst;

  rr_arbiter #(
    .N     (NUM_UNITS),
    .IDX_W (SRC_W)
  ) u_rr (
    .req_i    (req_valid),
    .ptr_i    (ptr_q),
    .enable_i (load),
    .grant_o  (req_ready),
    .idx_o    (gnt_idx),
    .any_o    (gnt_any)
  );

  // Gather the granted unit's payload.
  always_comb begin
    sel.id     = req_id[gnt_idx*RS_ID_WIDTH +: RS_ID_WIDTH];
    sel.result = req_result[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
    sel.cr     = req_cr[gnt_idx*4 +: 4];
    sel.xer    = req_xer[gnt_idx*3 +: 3];
  end

  // Next state of the output register and round-robin pointer.
  always_comb begin
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    out_src_d   = out_src_q;
    if (load) begin
      if (gnt_any) begin
        out_d       = sel;
        out_src_d   = gnt_idx;
        out_valid_d = 1'b1;
        ptr_d       = (gnt_idx == LAST_UNIT) ? '0 : gnt_idx + SRC_W'(1);
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  // Register the output stage and pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      out_src_q   <= '0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      out_src_q   <= out_src_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_id     = out_q.id;
  assign out_result = out_q.result;
  assign out_cr     = out_q.cr;
  assign out_xer    = out_q.xer;
  assign out_src    = out_src_q;

`ifdef RESULT_ARB_PERF_CNT_EN
  logic [31:0] perf_grants_q, perf_grants_d;
  logic [31:0] perf_conflicts_q, perf_conflicts_d;

  // Count bus handshakes and contended arbitration cycles; both wrap.
  always_comb begin
    perf_grants_d    = perf_grants_q;
    perf_conflicts_d = perf_conflicts_q;
    if (out_valid_q && out_ready) perf_grants_d = perf_grants_q + 32'd1;
    if (load && ($countones(req_valid) >= 2)) perf_conflicts_d = perf_conflicts_q + 32'd1;
  end

  // Perf counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_grants_q    <= '0;
      perf_conflicts_q <= '0;
    end else begin
      perf_grants_q    <= perf_grants_d;
      perf_conflicts_q <= perf_conflicts_d;
    end
  end

  assign perf_grants    = perf_grants_q;
  assign perf_conflicts = perf_conflicts_q;
`endif

  // A waiting unit must keep its request and payload until granted.
  for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_hold_chk
    a_hold: assert property (@(posedge clk) disable iff (rst)
      (req_valid[gi] && !req_ready[gi]) |=>
        (req_valid[gi]
         && $stable(req_id[gi*RS_ID_WIDTH +: RS_ID_WIDTH])
         && $stable(req_result[gi*DATA_WIDTH +: DATA_WIDTH])
         && $stable(req_cr[gi*4 +: 4])
         && $stable(req_xer[gi*3 +: 3])));
  end

endmodule
